multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
// - FSM that sequences the RV32I core's datapath over multiple cycles: fetch, decode, execute, memory, writeback.
// - Sits between the combinational control_unit and the registers (IR, PC, register file).
// - Turns control_unit's decoded levels (mem_read/mem_write/reg_write) into one-cycle write-enable pulses.
// - Drives valid/grant handshakes on separate instruction and data memory ports.
// PARAMETERS
// - CNT_W        32  width of retired-instruction counter instret
// - TIMEOUT_CYC  64  wait-state cycle limit before fault; used only with SEQ_MEM_TIMEOUT_EN; range 1..65535
// PORTS
// - clk          in   1      single clock, rising edge
// - rst          in   1      synchronous, active-high reset
// - run          in   1      level; permits starting new instructions
// - inst_opcode  in   7      IR[6:0], valid from DECODE onward
// - dec_mem_read in   1      control_unit mem_read
// - dec_mem_write in  1      control_unit mem_write
// - dec_reg_write in  1      control_unit reg_write
// - imem_req     out  1      instruction fetch request, address = PC
// - imem_gnt     in   1      fetch request accepted
// - imem_rvalid  in   1      fetch data valid
// - dmem_req     out  1      data request, address = ALU result
// - dmem_we      out  1      data request is a store; valid only while dmem_req=1
// - dmem_gnt     in   1      data request accepted
// - dmem_rvalid  in   1      load data valid
// - ir_we        out  1      IR load strobe
// - pc_we        out  1      PC update strobe; PC source comes from control_unit pc_select
// - rf_we        out  1      register-file write strobe
// - busy         out  1      state not IDLE and not FAULT
// - fault        out  1      sticky fault flag
// - fault_cause  out  2      01 illegal opcode; 10 memory timeout; 00 none
// - instret      out  CNT_W  count of retired instructions
// BEHAVIOUR
// - Reset (rst=1 at a clk edge, any state):
//   - state=IDLE; all outputs 0; instret=0; fault_cause=00.
//   - Any in-flight request is abandoned. Stale gnt/rvalid is ignored in IDLE, and rvalid is ignored in FETCH/MEM.
// - Valid opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111.
// - States and transitions:
//   - IDLE: run=1 -> FETCH.
//   - FETCH: imem_req=1, held until imem_gnt. Same-cycle gnt -> FWAIT.
//   - FWAIT: wait for imem_rvalid. On rvalid, ir_we=1 for that cycle -> DECODE.
//   - DECODE: 1 cycle so control_unit settles on the new IR. Illegal opcode -> FAULT. Otherwise -> EXEC.
//   - EXEC: 1 cycle; ALU and branch flags settle. dec_mem_read or dec_mem_write -> MEM, else -> WB.
//   - MEM: dmem_req=1 and dmem_we=dec_mem_write, both held stable until dmem_gnt.
//     On gnt, a store -> WB and a load -> MWAIT.
//   - MWAIT: wait for dmem_rvalid -> WB. rf_we is not asserted here.
//   - WB: 1 cycle with pc_we=1, rf_we=dec_reg_write, instret+=1.
//     Then run=1 -> FETCH, else IDLE.
//   - FAULT: no requests or strobes; fault=1. Exit only via rst.
// - run=0 mid-instruction: the current instruction completes through WB, then IDLE.
// - Strobes ir_we, pc_we and rf_we: each exactly one cycle per instruction; never two in the same cycle except pc_we+rf_we in WB.
// - instret wraps from 2^CNT_W-1 to 0 with no flag.
// - Latency with gnt in the request cycle and rvalid on the next cycle:
//   - ALU, branch, jump: 5 cycles per instruction.
//   - Store: 6 cycles per instruction.
//   - Load: 7 cycles per instruction.
// - Simultaneous rst and any handshake event: rst wins.
// CONFIGURATION
// - SEQ_MEM_TIMEOUT_EN defined:
//   - A 16-bit wait counter clears on every state change and counts each cycle spent in FETCH, FWAIT, MEM or MWAIT.
//   - When the counter reaches TIMEOUT_CYC while the awaited handshake is still low -> FAULT with fault_cause=10.
//     Requests drop in that same transition.
// - SEQ_MEM_TIMEOUT_EN undefined: no counter is built; waits are unbounded; TIMEOUT_CYC is ignored; fault_cause=10 never occurs.
// TESTING
// - Reset: rst=1 for 2 cycles in any state -> all outputs 0, instret=0, busy=0. A stale imem_rvalid afterwards is ignored.
// - ADD (0x002081B3), zero-wait memory, run=1 -> imem_req cycle 0, ir_we cycle 1, pc_we+rf_we cycle 4, instret=1, imem_req cycle 5.
// - LW (opcode 0000011), dmem_gnt held off 3 cycles -> dmem_req=1 and dmem_we=0 stable for 4 cycles.
//   Then rf_we exactly once, in the cycle after rvalid.
// - SW (opcode 0100011) -> dmem_we=1 with dmem_req; WB has pc_we=1, rf_we=0; MWAIT is skipped.
// - Opcode 1111111 -> FAULT after DECODE with fault=1, fault_cause=01. ir_we was pulsed once, pc_we and rf_we never, and there is no further imem_req until rst.
// - Memory timeout, imem_gnt tied low:
//   - With SEQ_MEM_TIMEOUT_EN and TIMEOUT_CYC=8 -> fault=1, fault_cause=10 after 8 FETCH cycles.
//   - Without the macro -> imem_req is still 1 after 100 cycles.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// Instruction- and data-memory request/grant/rvalid bundle between the
// multicycle sequencer (master) and the memory subsystem (slave).
interface multicycle_sequencer_if;
  logic imem_req;
  logic imem_gnt;
  logic imem_rvalid;
  logic dmem_req;
  logic dmem_we;
  logic dmem_gnt;
  logic dmem_rvalid;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle RV32I sequencer: FETCH/FWAIT/DECODE/EXEC/MEM/MWAIT/WB with one-cycle strobes.
// Optional wait-state watchdog enabled by defining SEQ_MEM_TIMEOUT_EN.
module multicycle_sequencer #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [6:0]            inst_opcode,
  input  logic                  dec_mem_read,
  input  logic                  dec_mem_write,
  input  logic                  dec_reg_write,
  multicycle_sequencer_if.master mem,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  rf_we,
  output logic                  busy,
  output logic                  fault,
  output logic [1:0]            fault_cause,
  output logic [CNT_W-1:0]      instret
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FWAIT,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_MWAIT,
    S_WB,
    S_FAULT
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_timeout_range_bad
    $error("multicycle_sequencer: TIMEOUT_CYC out of range 1..65535");
  end

  state_t           state_reg, state_next;
  logic [1:0]       fault_cause_reg, fault_cause_next;
  logic [CNT_W-1:0] instret_reg, instret_next;
  logic             timeout_hit;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b1100111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic        in_wait;

  assign in_wait = (state_reg == S_FETCH) || (state_reg == S_FWAIT) ||
                   (state_reg == S_MEM)   || (state_reg == S_MWAIT);

  // The counter holds the number of cycles already spent in the current wait state.
  assign timeout_hit = in_wait && (wait_cnt_reg == TIMEOUT_LAST);

  always_comb begin
    wait_cnt_next = 16'd0;
    if (in_wait && (state_next == state_reg)) begin
      wait_cnt_next = wait_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= 16'd0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    fault_cause_next = fault_cause_reg;
    instret_next     = instret_reg;
    mem.imem_req     = 1'b0;
    mem.dmem_req     = 1'b0;
    mem.dmem_we      = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    rf_we            = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_gnt) begin
          state_next = S_FWAIT;
        end else if (timeout_hit) begin
          state_next       = S_FAULT;
          fault_cause_next = CAUSE_TIMEOUT;
        end
      end
      S_FWAIT: begin
        if (mem.imem_rvalid) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next       = S_FAULT;
          fault_cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (!opcode_legal(inst_opcode)) begin
          state_next       = S_FAULT;
          fault_cause_next = CAUSE_ILLEGAL;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        state_next = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = dec_mem_write;
        if (mem.dmem_gnt) begin
          state_next = dec_mem_write ? S_WB : S_MWAIT;
        end else if (timeout_hit) begin
          state_next       = S_FAULT;
          fault_cause_next = CAUSE_TIMEOUT;
        end
      end
      S_MWAIT: begin
        if (mem.dmem_rvalid) begin
          state_next = S_WB;
        end else if (timeout_hit) begin
          state_next       = S_FAULT;
          fault_cause_next = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        pc_we        = 1'b1;
        rf_we        = dec_reg_write;
        instret_next = instret_reg + CNT_W'(1);
        state_next   = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      fault_cause_reg <= CAUSE_NONE;
      instret_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      fault_cause_reg <= fault_cause_next;
      instret_reg     <= instret_next;
    end
  end

  assign busy        = (state_reg != S_IDLE) && (state_reg != S_FAULT);
  assign fault       = (state_reg == S_FAULT);
  assign fault_cause = fault_cause_reg;
  assign instret     = instret_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: reset, ADD, LW with wait states, SW,
// illegal opcode, reset precedence and the fetch-timeout behaviour (SEQ_MEM_TIMEOUT_EN).
module tb_multicycle_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [6:0]  inst_opcode;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_reg_write;
  logic        ir_we, pc_we, rf_we, busy, fault;
  logic [1:0]  fault_cause;
  logic [31:0] instret;
  logic [7:0]  outs;

  int tests = 0;
  int fails = 0;

  multicycle_sequencer_if mif ();

  multicycle_sequencer #(
    .CNT_W      (32),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .inst_opcode  (inst_opcode),
    .dec_mem_read (dec_mem_read),
    .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write),
    .mem          (mif.master),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .rf_we        (rf_we),
    .busy         (busy),
    .fault        (fault),
    .fault_cause  (fault_cause),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  // Bit order: imem_req dmem_req dmem_we ir_we pc_we rf_we busy fault
  assign outs = {mif.imem_req, mif.dmem_req, mif.dmem_we, ir_we, pc_we, rf_we, busy, fault};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hs(input logic ig, input logic irv, input logic dg, input logic drv);
    mif.imem_gnt    = ig;
    mif.imem_rvalid = irv;
    mif.dmem_gnt    = dg;
    mif.dmem_rvalid = drv;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0;
    inst_opcode = 7'h00; dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_reg_write = 1'b0;
    hs(0, 0, 0, 0);

    // Reset and stale handshakes in IDLE
    cyc(); cyc();
    chk("reset_outs", {24'd0, outs}, 32'h00);
    chk("reset_instret", instret, 32'd0);
    chk("reset_cause", {30'd0, fault_cause}, 32'd0);
    rst = 1'b0;
    hs(1, 1, 1, 1);
    chk("idle_stale_hs", {24'd0, outs}, 32'h00);
    cyc(); hs(0, 0, 0, 0);
    chk("idle_stays", {24'd0, outs}, 32'h00);

    // ADD 0x002081B3, zero-wait memory
    run = 1'b1; inst_opcode = 7'b0110011; dec_reg_write = 1'b1;
    cyc(); hs(1, 0, 0, 0); chk("add_c0_fetch", {24'd0, outs}, 32'b1000_0010);
    cyc(); hs(0, 1, 0, 0); chk("add_c1_irwe", {24'd0, outs}, 32'b0001_0010);
    cyc(); hs(0, 0, 0, 0); chk("add_c2_decode", {24'd0, outs}, 32'b0000_0010);
    cyc(); chk("add_c3_exec", {24'd0, outs}, 32'b0000_0010);
    cyc(); chk("add_c4_wb", {24'd0, outs}, 32'b0000_1110);
    chk("add_c4_instret", instret, 32'd0);
    cyc(); chk("add_c5_fetch", {24'd0, outs}, 32'b1000_0010);
    chk("add_instret", instret, 32'd1);
    $display("[TB] ADD retired, instret=%0d", instret);

    // LW with dmem_gnt held off 3 cycles, run dropped during WB
    inst_opcode = 7'b0000011; dec_mem_read = 1'b1; dec_reg_write = 1'b1;
    hs(1, 0, 0, 0);
    cyc(); hs(0, 1, 0, 0); chk("lw_irwe", {24'd0, outs}, 32'b0001_0010);
    cyc(); hs(0, 0, 0, 0); chk("lw_decode", {24'd0, outs}, 32'b0000_0010);
    cyc(); chk("lw_exec", {24'd0, outs}, 32'b0000_0010);
    for (int i = 0; i < 4; i++) begin
      cyc(); hs(0, 0, (i == 3), 0);
      chk($sformatf("lw_mem_%0d", i), {24'd0, outs}, 32'b0100_0010);
    end
    cyc(); hs(0, 0, 0, 0); chk("lw_mwait", {24'd0, outs}, 32'b0000_0010);
    cyc(); hs(0, 0, 0, 1); chk("lw_mwait_rvalid", {24'd0, outs}, 32'b0000_0010);
    cyc(); hs(0, 0, 0, 0); run = 1'b0; chk("lw_wb", {24'd0, outs}, 32'b0000_1110);
    cyc(); chk("lw_idle", {24'd0, outs}, 32'h00);
    chk("lw_instret", instret, 32'd2);
    $display("[TB] LW retired, instret=%0d", instret);

    // SW, run dropped mid-instruction
    inst_opcode = 7'b0100011; dec_mem_read = 1'b0; dec_mem_write = 1'b1; dec_reg_write = 1'b0;
    run = 1'b1;
    cyc(); hs(1, 0, 0, 0); chk("sw_fetch", {24'd0, outs}, 32'b1000_0010);
    cyc(); hs(0, 1, 0, 0); chk("sw_irwe", {24'd0, outs}, 32'b0001_0010);
    cyc(); hs(0, 0, 0, 0); run = 1'b0; chk("sw_decode", {24'd0, outs}, 32'b0000_0010);
    cyc(); chk("sw_exec", {24'd0, outs}, 32'b0000_0010);
    cyc(); hs(0, 0, 1, 0); chk("sw_mem", {24'd0, outs}, 32'b0110_0010);
    cyc(); hs(0, 0, 0, 0); chk("sw_wb", {24'd0, outs}, 32'b0000_1010);
    cyc(); chk("sw_idle", {24'd0, outs}, 32'h00);
    chk("sw_instret", instret, 32'd3);
    $display("[TB] SW retired, instret=%0d", instret);

    // Illegal opcode 1111111
    inst_opcode = 7'b1111111; dec_mem_write = 1'b0; dec_reg_write = 1'b1;
    run = 1'b1;
    cyc(); hs(1, 0, 0, 0); chk("ill_fetch", {24'd0, outs}, 32'b1000_0010);
    cyc(); hs(0, 1, 0, 0); chk("ill_irwe", {24'd0, outs}, 32'b0001_0010);
    cyc(); hs(0, 0, 0, 0); chk("ill_decode", {24'd0, outs}, 32'b0000_0010);
    cyc(); chk("ill_fault", {24'd0, outs}, 32'b0000_0001);
    chk("ill_cause", {30'd0, fault_cause}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); hs(1, 1, 1, 1);
      chk($sformatf("ill_sticky_%0d", i), {24'd0, outs}, 32'b0000_0001);
    end
    chk("ill_instret", instret, 32'd3);
    $display("[TB] illegal opcode trapped, cause=%0d", fault_cause);

    // Reset out of FAULT, reset beating a grant, stale rvalid afterwards
    rst = 1'b1; hs(0, 0, 0, 0);
    cyc(); cyc();
    chk("rst2_outs", {24'd0, outs}, 32'h00);
    chk("rst2_cause", {30'd0, fault_cause}, 32'd0);
    chk("rst2_instret", instret, 32'd0);
    rst = 1'b0; inst_opcode = 7'b0110011;
    cyc(); chk("rst3_fetch", {24'd0, outs}, 32'b1000_0010);
    rst = 1'b1; hs(1, 0, 0, 0);
    cyc(); chk("rst_wins_gnt", {24'd0, outs}, 32'h00);
    rst = 1'b0; run = 1'b0; hs(0, 1, 0, 0);
    chk("stale_rvalid_a", {24'd0, outs}, 32'h00);
    cyc(); chk("stale_rvalid_b", {24'd0, outs}, 32'h00);
    $display("[TB] reset sequence done");

    // Fetch with imem_gnt tied low
    hs(0, 0, 0, 0); run = 1'b1;
    cyc();
`ifdef SEQ_MEM_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_fetch_%0d", i), {24'd0, outs}, 32'b1000_0010);
      cyc();
    end
    chk("to_fault", {24'd0, outs}, 32'b0000_0001);
    chk("to_cause", {30'd0, fault_cause}, 32'd2);
`else
    chk("nto_fetch_first", {24'd0, outs}, 32'b1000_0010);
    for (int i = 0; i < 100; i++) cyc();
    chk("nto_fetch_100", {24'd0, outs}, 32'b1000_0010);
    chk("nto_cause", {30'd0, fault_cause}, 32'd0);
`endif
    $display("[TB] gnt-low fetch done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
